// File: rtl/dds_load_if.sv
// dds_load_if: CPU-side request/status bundle for the DDS load sequencer.
//   init_req   : one-cycle strobe, reset the DDS and enter serial mode
//   load_req   : one-cycle strobe, load freq_word/phase/power_down
//   freq_word  : 32-bit frequency tuning word, sampled with load_req
//   phase      : 5-bit phase word, sampled with load_req
//   power_down : DDS power-down bit, sampled with load_req
//   busy       : an operation is running or pending
//   done       : one-cycle pulse when an operation completes
//   overrun    : one-cycle pulse when a pending load is overwritten
interface dds_load_if;
  logic        init_req;
  logic        load_req;
  logic [31:0] freq_word;
  logic [4:0]  phase;
  logic        power_down;
  logic        busy;
  logic        done;
  logic        overrun;

  modport master (
    output init_req, load_req, freq_word, phase, power_down,
    input  busy, done, overrun
  );

  modport slave (
    input  init_req, load_req, freq_word, phase, power_down,
    output busy, done, overrun
  );
endinterface

// File: rtl/dds_load_ctrl.sv
// dds_load_ctrl: serial-load sequencer for an AD9850-class DDS.
// Runs either an init sequence (RESET pulse, one W_CLK pulse to enter serial
// mode, FQ_UD) or a 40-bit serial load (LSB first, then FQ_UD). One load and
// one init request can be held pending while an operation is in progress.
// Ports:
//   SYSCLK, NSYSRESET : clock, asynchronous active-low reset
//   bus               : dds_load_if.slave (requests in, busy/done/overrun out)
//   ddsreset, ddswclk, ddsdata, ddsfqud : DDS RESET, W_CLK, D7, FQ_UD pins
module dds_load_ctrl #(
  parameter int CLK_DIV      = 2,
  parameter int RESET_CYCLES = 8,
  parameter int FQUD_CYCLES  = 4
) (
  input  logic       SYSCLK,
  input  logic       NSYSRESET,
  dds_load_if.slave  bus,
  output logic       ddsreset,
  output logic       ddswclk,
  output logic       ddsdata,
  output logic       ddsfqud
);

  typedef enum logic [2:0] {
    IDLE, RST, GAP, WPULSE, SHIFT_LO, SHIFT_HI, FQUD, DONE
  } state_t;

  localparam int MAX_A   = (CLK_DIV > RESET_CYCLES) ? CLK_DIV : RESET_CYCLES;
  localparam int MAX_CNT = (MAX_A > FQUD_CYCLES) ? MAX_A : FQUD_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] FQUD_LAST = CNT_W'(FQUD_CYCLES - 1);
  localparam logic [5:0]       LAST_BIT  = 6'd39;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       bit_idx;
  logic [39:0]      sreg;       // sreg[0] is the bit currently on ddsdata
  logic [39:0]      pend_word;
  logic             pend_valid;
  logic             pend_init;
  logic             busy_q;
  logic             done_q;
  logic             overrun_q;

  // Serial word layout: freq_word in bits 31:0, two control zeros, power_down,
  // then phase in bits 39:35. Bit 0 goes out first.
  function automatic logic [39:0] pack_word(input logic [31:0] f,
                                            input logic [4:0]  p,
                                            input logic        pd);
    return {p, pd, 2'b00, f};
  endfunction

  logic [39:0] new_word;
  logic [39:0] start_word;

  assign new_word   = pack_word(bus.freq_word, bus.phase, bus.power_down);
  // A load started from DONE takes the older pending word before a fresh one.
  assign start_word = pend_valid ? pend_word : new_word;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

  // NOTE: every register here, the 40-bit word buffers included, sits on the
  // async reset so a reset mid-transfer can never replay stale data or leave
  // a pending request behind.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sreg       <= '0;
      pend_word  <= '0;
      pend_valid <= 1'b0;
      pend_init  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      ddsreset   <= 1'b0;
      ddswclk    <= 1'b0;
      ddsdata    <= 1'b0;
      ddsfqud    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block
      // intentionally override the defaults below within the same edge.
      done_q    <= 1'b0;
      overrun_q <= 1'b0;

      // Requests arriving mid-operation go into the pending slots.
      if (state != IDLE && state != DONE) begin
        if (bus.load_req) begin
          pend_word  <= new_word;
          pend_valid <= 1'b1;
          overrun_q  <= pend_valid;
        end
        if (bus.init_req) pend_init <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (pend_init || bus.init_req) begin
            state     <= RST;
            ddsreset  <= 1'b1;
            cnt       <= RST_LAST;
            busy_q    <= 1'b1;
            pend_init <= 1'b0;
            if (bus.load_req) begin
              pend_word  <= new_word;
              pend_valid <= 1'b1;
              overrun_q  <= pend_valid;
            end
          end else if (pend_valid || bus.load_req) begin
            state      <= SHIFT_LO;
            sreg       <= start_word;
            ddsdata    <= start_word[0];
            bit_idx    <= '0;
            cnt        <= DIV_LAST;
            busy_q     <= 1'b1;
            // Pending slot is consumed; a load arriving now refills it.
            pend_valid <= pend_valid && bus.load_req;
            if (pend_valid && bus.load_req) pend_word <= new_word;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        RST: begin
          if (cnt == '0) begin
            state    <= GAP;
            ddsreset <= 1'b0;
            cnt      <= DIV_LAST;
          end else cnt <= cnt - 1'b1;
        end

        GAP: begin
          if (cnt == '0) begin
            state   <= WPULSE;
            ddswclk <= 1'b1;
            cnt     <= DIV_LAST;
          end else cnt <= cnt - 1'b1;
        end

        WPULSE: begin
          if (cnt == '0) begin
            state   <= FQUD;
            ddswclk <= 1'b0;
            ddsfqud <= 1'b1;
            cnt     <= FQUD_LAST;
          end else cnt <= cnt - 1'b1;
        end

        SHIFT_LO: begin
          if (cnt == '0) begin
            state   <= SHIFT_HI;
            ddswclk <= 1'b1;
            cnt     <= DIV_LAST;
          end else cnt <= cnt - 1'b1;
        end

        SHIFT_HI: begin
          if (cnt == '0) begin
            ddswclk <= 1'b0;
            if (bit_idx == LAST_BIT) begin
              state   <= FQUD;
              ddsdata <= 1'b0;
              ddsfqud <= 1'b1;
              cnt     <= FQUD_LAST;
            end else begin
              // Data moves only here, as W_CLK falls: full CLK_DIV setup/hold.
              state   <= SHIFT_LO;
              bit_idx <= bit_idx + 1'b1;
              sreg    <= sreg >> 1;
              ddsdata <= sreg[1];
              cnt     <= DIV_LAST;
            end
          end else cnt <= cnt - 1'b1;
        end

        FQUD: begin
          if (cnt == '0) begin
            state   <= DONE;
            ddsfqud <= 1'b0;
            done_q  <= 1'b1;
            // Stay busy through DONE only if something will follow it.
            busy_q  <= pend_valid || pend_init || bus.load_req || bus.init_req;
          end else cnt <= cnt - 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_load_ctrl.sv
// tb_dds_load_ctrl: self-checking bench for dds_load_ctrl. A table of single
// operations, hand-written multi-cycle sequences and a randomized run are
// checked against a request-level reference model (operation latencies and a
// one-deep pending slot) plus a pin monitor that decodes the serial stream.
module tb_dds_load_ctrl;
  localparam int CLK_DIV      = 2;
  localparam int RESET_CYCLES = 8;
  localparam int FQUD_CYCLES  = 4;
  localparam int LOAD_LAT     = 1 + 80 * CLK_DIV + FQUD_CYCLES;
  localparam int INIT_LAT     = 1 + RESET_CYCLES + 2 * CLK_DIV + FQUD_CYCLES;

  logic SYSCLK = 1'b0;
  logic NSYSRESET = 1'b0;
  logic ddsreset, ddswclk, ddsdata, ddsfqud;

  dds_load_if bus ();

  dds_load_ctrl #(
    .CLK_DIV     (CLK_DIV),
    .RESET_CYCLES(RESET_CYCLES),
    .FQUD_CYCLES (FQUD_CYCLES)
  ) dut (
    .SYSCLK   (SYSCLK),
    .NSYSRESET(NSYSRESET),
    .bus      (bus.slave),
    .ddsreset (ddsreset),
    .ddswclk  (ddswclk),
    .ddsdata  (ddsdata),
    .ddsfqud  (ddsfqud)
  );

  always #5 SYSCLK = ~SYSCLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Serial word from the bit-assignment rules, one bit at a time.
  function automatic logic [39:0] spec_word(input logic [31:0] f, input logic [4:0] p, input logic pd);
    logic [39:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) w[i] = f[i];
    w[34] = pd;
    for (int i = 0; i < 5; i++) w[35 + i] = p[i];
    return w;
  endfunction

  typedef struct {
    bit          is_init;
    logic [39:0] word;
  } op_t;

  typedef struct {
    int          nbits;
    logic [39:0] word;
  } obs_t;

  // ---------------- reference model (request level) ----------------
  op_t         exp_ops[$];
  bit          m_active, m_pv, m_pi;
  logic [39:0] m_pw;
  int          m_done_at;
  bit          exp_busy, exp_done, exp_ovr;

  task automatic m_start(input bit is_init, input logic [39:0] w);
    op_t o;
    o.is_init = is_init;
    o.word    = is_init ? 40'd0 : w;
    exp_ops.push_back(o);
    m_active  = 1'b1;
    m_done_at = cyc - 1 + (is_init ? INIT_LAT : LOAD_LAT);
  endtask

  always @(posedge SYSCLK) begin
    bit          ri, rl, old_pv;
    logic [39:0] w;
    cyc = cyc + 1;
    if (!NSYSRESET) begin
      m_active = 0; m_pv = 0; m_pi = 0; m_pw = '0;
      exp_busy = 0; exp_done = 0; exp_ovr = 0;
      exp_ops.delete();
    end else begin
      ri = bus.init_req;
      rl = bus.load_req;
      w  = spec_word(bus.freq_word, bus.phase, bus.power_down);
      exp_ovr = 0;
      if (m_active && (cyc - 1) < m_done_at) begin
        if (rl) begin
          exp_ovr = m_pv;
          m_pv = 1; m_pw = w;
        end
        if (ri) m_pi = 1;
      end else begin
        m_active = 0;
        if (m_pi || ri) begin
          m_start(1'b1, '0);
          m_pi = 0;
          if (rl) begin
            exp_ovr = m_pv;
            m_pv = 1; m_pw = w;
          end
        end else if (m_pv || rl) begin
          old_pv = m_pv;
          m_start(1'b0, old_pv ? m_pw : w);
          m_pv = old_pv && rl;
          if (m_pv) m_pw = w;
        end
      end
      exp_done = m_active && (cyc == m_done_at);
      exp_busy = m_active && ((cyc < m_done_at) || m_pv || m_pi);
    end
  end

  // ---------------- pin monitor ----------------
  obs_t        obs_q[$];
  logic [39:0] cur_word;
  int          cur_n, fq_len, rst_len;
  int          done_cnt, ovr_cnt, last_ovr_cyc, fq_rises;
  logic        prev_wclk, prev_fqud, prev_rst;

  always @(negedge SYSCLK) begin
    op_t  e;
    obs_t o;
    if (!NSYSRESET) begin
      check("reset_outputs", {bus.busy, bus.done, bus.overrun, ddsreset, ddswclk, ddsdata, ddsfqud}, '0);
      cur_n = 0; cur_word = '0; fq_len = 0; rst_len = 0;
      prev_wclk = 0; prev_fqud = 0; prev_rst = 0;
    end else begin
      check("status_busy_done_ovr", {bus.busy, bus.done, bus.overrun}, {exp_busy, exp_done, exp_ovr});
      if (ddswclk && !prev_wclk) begin
        check("wclk_edge_quiet", {ddsreset, ddsfqud}, 2'b00);
        if (cur_n < 40) cur_word[cur_n] = ddsdata;
        cur_n++;
      end
      if (ddsfqud && !prev_fqud) begin
        fq_rises++;
        if (exp_ops.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_fqud actual=1 expected=0 cycle=%0d", cyc);
        end else begin
          e = exp_ops.pop_front();
          check("op_nbits", cur_n, e.is_init ? 1 : 40);
          check("op_word", cur_word, e.word);
        end
        o.nbits = cur_n; o.word = cur_word;
        obs_q.push_back(o);
        cur_n = 0; cur_word = '0;
      end
      if (ddsfqud) fq_len++;
      else if (prev_fqud) begin check("fqud_width", fq_len, FQUD_CYCLES); fq_len = 0; end
      if (ddsreset) rst_len++;
      else if (prev_rst) begin check("reset_width", rst_len, RESET_CYCLES); rst_len = 0; end
      if (bus.done) done_cnt++;
      if (bus.overrun) begin ovr_cnt++; last_ovr_cyc = cyc; end
      prev_wclk = ddswclk; prev_fqud = ddsfqud; prev_rst = ddsreset;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic req(input bit i, input bit l, input logic [31:0] f, input logic [4:0] p, input bit pd);
    bus.init_req   = i;
    bus.load_req   = l;
    bus.freq_word  = f;
    bus.phase      = p;
    bus.power_down = pd;
    tick();
    bus.init_req = 0;
    bus.load_req = 0;
  endtask

  task automatic wait_done(input int max_cycles, output int at);
    at = -1;
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge SYSCLK);
      if (bus.done) begin at = cyc; break; end
    end
    if (at < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=none expected=done within %0d cycles", max_cycles);
    end
    tick();
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 1000 && cyc < target; k++) tick();
  endtask

  typedef struct {
    bit          is_init;
    logic [31:0] f;
    logic [4:0]  p;
    bit          pd;
    logic [39:0] exp_word;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int rc, at, d0, o0, f0, n;
    bus.init_req = 0; bus.load_req = 0;
    bus.freq_word = '0; bus.phase = '0; bus.power_down = 0;
    done_cnt = 0; ovr_cnt = 0; last_ovr_cyc = -1; fq_rises = 0;

    vecs[0] = '{1'b1, 32'h0,         5'h00, 1'b0, 40'h00_0000_0000, 17};
    vecs[1] = '{1'b0, 32'h0000_0001, 5'h10, 1'b0, 40'h80_0000_0001, 165};
    vecs[2] = '{1'b0, 32'hA5A5_A5A5, 5'h00, 1'b1, 40'h04_A5A5_A5A5, 165};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 5'h1F, 1'b1, 40'hFC_FFFF_FFFF, 165};
    vecs[4] = '{1'b0, 32'h8000_0000, 5'h01, 1'b0, 40'h08_8000_0000, 165};
    vecs[5] = '{1'b0, 32'h0000_0000, 5'h00, 1'b0, 40'h00_0000_0000, 165};

    repeat (3) tick();
    NSYSRESET = 1;
    tick();
    check("post_reset_idle", {bus.busy, ddsreset, ddswclk, ddsdata, ddsfqud}, '0);

    // Table: single operations from idle.
    for (int v = 0; v < 6; v++) begin
      rc = cyc;
      req(vecs[v].is_init, !vecs[v].is_init, vecs[v].f, vecs[v].p, vecs[v].pd);
      wait_done(400, at);
      check($sformatf("latency_%0d", v), at - rc, vecs[v].lat);
      check($sformatf("nbits_%0d", v), obs_q[obs_q.size()-1].nbits, vecs[v].is_init ? 1 : 40);
      check($sformatf("word_%0d", v), obs_q[obs_q.size()-1].word, vecs[v].exp_word);
      tick();
      check($sformatf("idle_after_%0d", v), bus.busy, 1'b0);
    end

    // A then B: back-to-back, no overrun.
    d0 = done_cnt; o0 = ovr_cnt;
    rc = cyc;
    req(0, 1, 32'h1234_5678, 5'h0A, 0);
    run_to(rc + 20);
    req(0, 1, 32'h8765_4321, 5'h15, 1);
    wait_done(400, at);
    check("ab_done_a", at - rc, 165);
    wait_done(400, at);
    check("ab_done_b", at - rc, 330);
    check("ab_done_count", done_cnt - d0, 2);
    check("ab_no_overrun", ovr_cnt - o0, 0);
    check("ab_word_a", obs_q[obs_q.size()-2].word, 40'h50_1234_5678);
    check("ab_word_b", obs_q[obs_q.size()-1].word, 40'hAC_8765_4321);
    tick();

    // A, B, C: B overwritten by C, overrun one cycle after C.
    d0 = done_cnt; o0 = ovr_cnt;
    rc = cyc;
    req(0, 1, 32'h0000_00AA, 5'h00, 0);
    run_to(rc + 20);
    req(0, 1, 32'h0000_00BB, 5'h00, 0);
    run_to(rc + 30);
    req(0, 1, 32'h0000_00CC, 5'h00, 0);
    wait_done(400, at);
    wait_done(400, at);
    check("abc_overrun_count", ovr_cnt - o0, 1);
    check("abc_overrun_cycle", last_ovr_cyc - rc, 31);
    check("abc_done_count", done_cnt - d0, 2);
    check("abc_word_a", obs_q[obs_q.size()-2].word, 40'h00_0000_00AA);
    check("abc_word_c", obs_q[obs_q.size()-1].word, 40'h00_0000_00CC);
    tick();

    // init and load in the same cycle: init first, then the load.
    rc = cyc;
    req(1, 1, 32'hA5A5_A5A5, 5'h03, 0);
    wait_done(400, at);
    check("il_done_init", at - rc, 17);
    wait_done(400, at);
    check("il_done_load", at - rc, 17 + 165);
    check("il_first_is_init", obs_q[obs_q.size()-2].nbits, 1);
    check("il_load_word", obs_q[obs_q.size()-1].word[31:0], 32'hA5A5_A5A5);
    tick();

    // Reset in the middle of a load.
    f0 = fq_rises; d0 = done_cnt;
    rc = cyc;
    req(0, 1, 32'hDEAD_BEEF, 5'h1F, 1);
    run_to(rc + 50);
    NSYSRESET = 0;
    #1;
    check("midreset_outputs", {bus.busy, bus.done, bus.overrun, ddsreset, ddswclk, ddsdata, ddsfqud}, '0);
    tick(); tick();
    NSYSRESET = 1;
    repeat (200) tick();
    check("midreset_no_fqud", fq_rises - f0, 0);
    check("midreset_no_done", done_cnt - d0, 0);
    check("midreset_idle", bus.busy, 1'b0);

    // Randomized requests against the reference model.
    for (int k = 0; k < 3000; k++) begin
      bus.init_req   = ($urandom_range(0, 199) == 0);
      bus.load_req   = ($urandom_range(0, 99) < 3);
      bus.freq_word  = $urandom;
      bus.phase      = 5'($urandom_range(0, 31));
      bus.power_down = 1'($urandom_range(0, 1));
      tick();
    end
    bus.init_req = 0; bus.load_req = 0;
    n = 0;
    while (n < 3000 && (bus.busy || exp_ops.size() != 0)) begin tick(); n++; end
    check("random_drained", {bus.busy, exp_ops.size() != 0}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dds_load_ctrl.md
Name: dds_load_ctrl

Overview:
- Sequences the serial load of the AD9850-class DDS that produces the NMR excitation carrier.
- Drives ddsreset, ddswclk, ddsdata and ddsfqud.
- Accepts a one-shot init request (hardware reset plus serial-mode entry) and frequency/phase load requests from the CPU register file.
- Buffers one pending load so a CPU write during an active transfer is not lost.

Parameters:
- CLK_DIV, 2, half-period of ddswclk in SYSCLK cycles (>=1).
- RESET_CYCLES, 8, ddsreset high time in SYSCLK cycles (>=1).
- FQUD_CYCLES, 4, ddsfqud high time in SYSCLK cycles (>=1).

Ports:
- SYSCLK  in  1  system clock; all logic on rising edge.
- NSYSRESET  in  1  asynchronous active-low reset.
- init_req  in  1  single-cycle strobe: reset DDS and enter serial mode.
- load_req  in  1  single-cycle strobe: load freq_word/phase/power_down.
- freq_word  in  32  frequency tuning word, sampled on the load_req cycle.
- phase  in  5  phase word, sampled with load_req.
- power_down  in  1  DDS power-down bit, sampled with load_req.
- busy  out  1  operation in progress or pending.
- done  out  1  one-cycle pulse when an operation completes.
- overrun  out  1  one-cycle pulse when a pending load is overwritten.
- ddsreset  out  1  DDS RESET pin.
- ddswclk  out  1  DDS W_CLK pin.
- ddsdata  out  1  DDS D7 serial data pin.
- ddsfqud  out  1  DDS FQ_UD pin.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - All outputs go to 0.
  - State returns to IDLE; pending load and pending init are cleared.
  - No partial FQ_UD is ever issued after reset.
- States: IDLE, RST, GAP, WPULSE, SHIFT_LO, SHIFT_HI, FQUD, DONE.
- Serial word, 40 bits, sent bit 0 first:
  - bits 0..31 = freq_word[0..31];
  - bits 32,33 = 0;
  - bit 34 = power_down;
  - bits 35..39 = phase[0..4].
- Load from IDLE (load_req=1, init_req=0):
  - On the sampling edge: latch the word; busy=1; ddsdata=bit0; enter SHIFT_LO.
  - Each bit: CLK_DIV cycles wclk=0 (SHIFT_LO), then CLK_DIV cycles wclk=1 (SHIFT_HI).
  - ddsdata changes only on entry to SHIFT_LO, so setup and hold are each CLK_DIV cycles.
  - After bit 39's high phase: FQUD, ddsfqud=1 for FQUD_CYCLES, ddsdata=0.
  - Then DONE for one cycle: done=1, wclk/fqud=0.
  - Latency: done asserts 1+80*CLK_DIV+FQUD_CYCLES cycles after the load_req sampling edge (165 at defaults).
- Init from IDLE (init_req=1):
  - RST: ddsreset=1 for RESET_CYCLES.
  - GAP: CLK_DIV cycles, all pins 0.
  - WPULSE: ddswclk=1 for CLK_DIV cycles (enters serial mode; D2..D0 strapped on board).
  - Then FQUD, then DONE as above.
  - done asserts 1+RESET_CYCLES+2*CLK_DIV+FQUD_CYCLES cycles after the sampling edge (17 at defaults).
- Simultaneous init_req and load_req in IDLE: init runs first; the load is captured as pending.
- Requests while not IDLE:
  - load_req latches into the one-deep pending buffer.
  - load_req while the buffer is already full overwrites it (newest wins) and pulses overrun the next cycle.
  - init_req sets pending_init (not counted as overrun).
- Leaving DONE:
  - If pending_init is set, start init next cycle (pending_init clears).
  - Otherwise, if a pending load exists, start it next cycle.
  - Otherwise go to IDLE.
  - busy stays 1 through DONE when any request is pending; otherwise busy=0 in DONE.
- A request arriving in the DONE cycle is treated as pending.
- No ddswclk edge is ever produced during ddsreset=1 or ddsfqud=1.

Test Plan:
- Release reset, pulse init_req -> ddsreset high exactly 8 cycles; one ddswclk pulse of 2 cycles; ddsfqud high 4 cycles; done at cycle 17; busy low after.
- load_req with freq_word=32'h0000_0001, phase=5'h10, power_down=0 -> ddsdata sampled on each ddswclk rise = 1, then 38 zeros, then 1 (bit 39); exactly 40 rising edges; done at cycle 165.
- load_req A, then load_req B at cycle 20 -> A sent fully; B begins the cycle after A's done with no gap; busy continuous; 2 done pulses; no overrun.
- load_req A, then B at cycle 20, then C at cycle 30 -> overrun pulse at cycle 31; serial output shows A then C; B never sent.
- init_req and load_req in the same cycle, freq_word=32'hA5A5_A5A5 -> init sequence first, then load; bits 0..31 on ddsdata = A5A5A5A5 LSB first.
- Assert NSYSRESET low at cycle 50 of a load -> all outputs 0 immediately; after release, no FQ_UD pulse and busy=0 until a new request.
